// File: rtl/z80_bus_responder.sv
// Z80 bus slave: byte memory, 256-port I/O space, IM2 vector on INTA and a completed-access counter.
// Define Z80_RESP_WAIT_EN to insert WAITS wait states per access; otherwise wait_n stays high.
module z80_bus_responder #(
  parameter int unsigned AW      = 16,
  parameter int unsigned WAITS   = 0,
  parameter logic [7:0]  IM2_VEC = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic [15:0] acc_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StHold   = 2'd3;

  if (AW < 1 || AW > 16 || WAITS > 7) begin : g_param_check
    $error("z80_bus_responder: AW must be 1..16 and WAITS 0..7");
  end

  logic [7:0] mem [2**AW];
  logic [7:0] io  [256];

  logic [1:0]  state_q, state_d;
  logic [7:0]  di_q;
  logic [15:0] acc_q;

  // Refresh cycles never decode: MRD needs rfsh_n high and refresh never pulls wr_n low.
  logic mrd, mwr, iord, iowr, inta, req;
  assign mrd  = !mreq_n && !rd_n && rfsh_n;
  assign mwr  = !mreq_n && !wr_n;
  assign iord = !iorq_n && !rd_n && m1_n;
  assign iowr = !iorq_n && !wr_n;
  assign inta = !iorq_n && !m1_n;
  assign req  = mrd || mwr || iord || iowr || inta;

  logic acc_en, mem_we, io_we, rd_en;
  assign acc_en = (state_q == StAccess) && req;
  assign mem_we = acc_en && mwr;
  assign io_we  = acc_en && iowr && !mwr;
  // A write wins over a simultaneous read, leaving di untouched.
  assign rd_en  = acc_en && !mwr && !iowr;

`ifdef Z80_RESP_WAIT_EN
  localparam logic [2:0] WaitLoad = 3'((WAITS > 0) ? (WAITS - 1) : 0);

  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
`ifdef Z80_RESP_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req) begin
`ifdef Z80_RESP_WAIT_EN
          if (WAITS == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
`else
          state_d = StAccess;
`endif
        end
      end
      StWait: begin
`ifdef Z80_RESP_WAIT_EN
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 3'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
`else
        state_d = StIdle;
`endif
      end
      StAccess: state_d = StHold;
      // Stay here until the strobe drops so a long strobe never repeats the access.
      StHold: begin
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      di_q    <= 8'h00;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (acc_en) begin
        acc_q <= acc_q + 16'd1;
      end
      if (rd_en) begin
        if (mrd) begin
          di_q <= mem[A[AW-1:0]];
        end else if (iord) begin
          di_q <= io[A[7:0]];
        end else if (inta) begin
          di_q <= IM2_VEC;
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain; reset only blocks the write via state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[A[AW-1:0]] <= dout;
    end
    if (io_we) begin
      io[A[7:0]] <= dout;
    end
  end

  assign di      = di_q;
  assign acc_cnt = acc_q;
`ifdef Z80_RESP_WAIT_EN
  assign wait_n  = (state_q != StWait);
`else
  assign wait_n  = 1'b1;
`endif

endmodule
